// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcode classes, funct3 codes, FSM states.
package memory_stage_pkg;
   localparam int OPCODE_WIDTH = 11;

   localparam int RTYPE      = 0;
   localparam int ITYPE      = 1;
   localparam int LOAD_WORD  = 2;
   localparam int STORE_WORD = 3;
   localparam int BRANCH     = 4;
   localparam int JAL        = 5;
   localparam int JALR       = 6;
   localparam int LUI        = 7;
   localparam int AUIPC      = 8;
   localparam int SYSTEM     = 9;
   localparam int FENCE      = 10;

   localparam logic [2:0] FUNCT_LB  = 3'd0;
   localparam logic [2:0] FUNCT_LH  = 3'd1;
   localparam logic [2:0] FUNCT_LW  = 3'd2;
   localparam logic [2:0] FUNCT_LBU = 3'd4;
   localparam logic [2:0] FUNCT_LHU = 3'd5;
   localparam logic [2:0] FUNCT_SB  = 3'd0;
   localparam logic [2:0] FUNCT_SH  = 3'd1;
   localparam logic [2:0] FUNCT_SW  = 3'd2;

   typedef enum logic {IDLE, BUSY} mem_state_t;

   // Opcode classes that produce a register-file write.
   function automatic logic writes_rd(input logic [OPCODE_WIDTH-1:0] op);
      return op[RTYPE] | op[ITYPE] | op[LOAD_WORD] | op[JAL] | op[JALR] | op[LUI] | op[AUIPC];
   endfunction
endpackage

// File: rtl/memory_stage_data_ram.sv
// Byte-enabled data RAM with a registered one-cycle ack. Reads are captured on the request edge,
// the write is committed on the ack edge so a reset before the ack drops it.
module stage_data_ram #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 256,
   localparam int AW    = $clog2(DEPTH),
   localparam int LANES = DWIDTH / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cyc,
   input  logic              stb,
   input  logic [AW-1:0]     addr,
   input  logic [LANES-1:0]  byte_enable,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              ack
);
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_addr_reg;
   logic [LANES-1:0]  wr_be_reg;
   logic [DWIDTH-1:0] wr_data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack <= 1'b0;
      else        ack <= cyc & stb & ~ack;
   end

   always_ff @(posedge clk) begin
      if (cyc && stb) begin
         rdata       <= mem[addr];
         wr_addr_reg <= addr;
         wr_be_reg   <= byte_enable;
         wr_data_reg <= wdata;
      end
      for (int i = 0; i < LANES; i++) begin
         if (ack && wr_be_reg[i]) mem[wr_addr_reg][8*i +: 8] <= wr_data_reg[8*i +: 8];
      end
   end
endmodule

// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: sized loads/stores against the local data RAM with a
// single outstanding request, plus the registered writeback payload and stall/flush to upstream.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int FUNCT_WIDTH = 3,
   parameter int MEM_DEPTH   = 256
) (
   input  logic                    me_clk,
   input  logic                    me_rst,
   input  logic                    me_i_ce,
   input  logic                    me_i_stall,
   input  logic                    me_i_flush,
   input  logic [DWIDTH-1:0]       me_i_rs2_data,
   input  logic [DWIDTH-1:0]       me_i_alu_value,
   input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
   input  logic [AWIDTH-1:0]       me_i_rd_addr,
   input  logic [DWIDTH-1:0]       me_i_rd_data,
   output logic                    me_o_ce,
   output logic                    me_o_stall,
   output logic                    me_o_flush,
   output logic [OPCODE_WIDTH-1:0] me_o_opcode,
   output logic [FUNCT_WIDTH-1:0]  me_o_funct3,
   output logic [DWIDTH-1:0]       me_o_load_data,
   output logic [AWIDTH-1:0]       me_o_rd_addr,
   output logic [DWIDTH-1:0]       me_o_rd_data,
   output logic                    me_o_rd_we
);
   localparam int RAM_AW = $clog2(MEM_DEPTH);
   localparam int LANES  = DWIDTH / 8;

   mem_state_t        state_reg, state_next;
   logic              accept, is_mem, mem_done, ram_ack;
   logic              ack_seen_reg, kill_reg;
   logic [1:0]        off, off_reg;
   logic [RAM_AW-1:0] word_idx;
   logic              me_o_cyc, me_o_stb;
   logic [LANES-1:0]  byte_enable;
   logic [DWIDTH-1:0] me_o_store_data, ram_rdata, load_value;
   logic [15:0]       lane_data;
   logic              unused_addr_bits;

   assign off              = me_i_alu_value[1:0];
   assign word_idx         = me_i_alu_value[RAM_AW+1:2];
   assign unused_addr_bits = ^me_i_alu_value[DWIDTH-1:RAM_AW+2];
   assign is_mem     = me_i_opcode[LOAD_WORD] | me_i_opcode[STORE_WORD];
   assign me_o_stall = me_i_stall | (state_reg == BUSY);
   assign me_o_flush = me_i_flush;
   assign accept     = me_i_ce & ~me_o_stall & ~me_i_flush;
   // The ack is a single pulse; remember it so a downstream stall can't lose it.
   assign mem_done   = (ram_ack | ack_seen_reg) & ~me_i_stall;
   assign me_o_rd_we = me_o_ce & writes_rd(me_o_opcode);

   always_comb begin
      state_next = state_reg;
      me_o_cyc   = 1'b0;
      me_o_stb   = 1'b0;
      case (state_reg)
         IDLE: if (accept && is_mem) begin
            state_next = BUSY;
            me_o_cyc   = 1'b1;
            me_o_stb   = 1'b1;
         end
         BUSY: if (mem_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Misaligned or unknown-size stores leave byte_enable at zero so nothing is written.
   always_comb begin
      byte_enable     = '0;
      me_o_store_data = me_i_rs2_data;
      if (me_i_opcode[STORE_WORD]) begin
         case (me_i_funct3)
            FUNCT_SB: begin
               byte_enable     = LANES'(1) << off;
               me_o_store_data = {LANES{me_i_rs2_data[7:0]}};
            end
            FUNCT_SH: if (off != 2'd3) begin
               byte_enable     = LANES'(3) << off;
               me_o_store_data = DWIDTH'(me_i_rs2_data[15:0]) << {off, 3'b000};
            end
            FUNCT_SW: if (off == 2'd0) byte_enable = '1;
            default: ;
         endcase
      end
   end

   stage_data_ram #(.DWIDTH(DWIDTH), .DEPTH(MEM_DEPTH)) u_ram (
      .clk(me_clk), .rst_n(me_rst), .cyc(me_o_cyc), .stb(me_o_stb), .addr(word_idx),
      .byte_enable(byte_enable), .wdata(me_o_store_data), .rdata(ram_rdata), .ack(ram_ack)
   );

   assign lane_data = 16'(ram_rdata >> {off_reg, 3'b000});

   always_comb begin
      load_value = '0;
      case (me_o_funct3)
         FUNCT_LB:  load_value = {{(DWIDTH-8){lane_data[7]}}, lane_data[7:0]};
         FUNCT_LBU: load_value = DWIDTH'(lane_data[7:0]);
         FUNCT_LH:  if (off_reg != 2'd3) load_value = {{(DWIDTH-16){lane_data[15]}}, lane_data};
         FUNCT_LHU: if (off_reg != 2'd3) load_value = DWIDTH'(lane_data);
         FUNCT_LW:  if (off_reg == 2'd0) load_value = ram_rdata;
         default: ;
      endcase
   end

   always_ff @(posedge me_clk or negedge me_rst) begin
      if (!me_rst) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_ff @(posedge me_clk or negedge me_rst) begin
      if (!me_rst) begin
         ack_seen_reg   <= 1'b0;
         kill_reg       <= 1'b0;
         off_reg        <= '0;
         me_o_ce        <= 1'b0;
         me_o_opcode    <= '0;
         me_o_funct3    <= '0;
         me_o_load_data <= '0;
         me_o_rd_addr   <= '0;
         me_o_rd_data   <= '0;
      end else begin
         if (state_reg == IDLE || mem_done) begin
            ack_seen_reg <= 1'b0;
            kill_reg     <= 1'b0;
         end else begin
            ack_seen_reg <= ack_seen_reg | ram_ack;
            kill_reg     <= kill_reg | me_i_flush;
         end
         // Opcode/funct3/rd of a memory op are parked in the output registers while BUSY.
         if (me_i_flush) begin
            me_o_ce <= 1'b0;
         end else if (!me_i_stall) begin
            me_o_ce <= 1'b0;
            if (state_reg == BUSY && mem_done) begin
               me_o_ce        <= ~kill_reg;
               me_o_load_data <= load_value;
               me_o_rd_data   <= load_value;
            end else if (accept) begin
               me_o_opcode  <= me_i_opcode;
               me_o_funct3  <= me_i_funct3;
               me_o_rd_addr <= me_i_rd_addr;
               off_reg      <= off;
               if (!is_mem) begin
                  me_o_ce      <= 1'b1;
                  me_o_rd_data <= me_i_rd_data;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized and directed bench for memory_stage against a byte-level memory model.
module tb_memory_stage;
   import memory_stage_pkg::*;

   logic                    me_clk, me_rst;
   logic                    me_i_ce, me_i_stall, me_i_flush;
   logic [31:0]             me_i_rs2_data, me_i_alu_value, me_i_rd_data;
   logic [OPCODE_WIDTH-1:0] me_i_opcode;
   logic [2:0]              me_i_funct3;
   logic [4:0]              me_i_rd_addr;
   logic                    me_o_ce, me_o_stall, me_o_flush, me_o_rd_we;
   logic [OPCODE_WIDTH-1:0] me_o_opcode;
   logic [2:0]              me_o_funct3;
   logic [31:0]             me_o_load_data, me_o_rd_data;
   logic [4:0]              me_o_rd_addr;

   int vec_count = 0;
   int err_count = 0;
   bit [31:0] model_mem [256];

   memory_stage u_dut (
      .me_clk(me_clk), .me_rst(me_rst), .me_i_ce(me_i_ce), .me_i_stall(me_i_stall),
      .me_i_flush(me_i_flush), .me_i_rs2_data(me_i_rs2_data), .me_i_alu_value(me_i_alu_value),
      .me_i_opcode(me_i_opcode), .me_i_funct3(me_i_funct3), .me_i_rd_addr(me_i_rd_addr),
      .me_i_rd_data(me_i_rd_data), .me_o_ce(me_o_ce), .me_o_stall(me_o_stall),
      .me_o_flush(me_o_flush), .me_o_opcode(me_o_opcode), .me_o_funct3(me_o_funct3),
      .me_o_load_data(me_o_load_data), .me_o_rd_addr(me_o_rd_addr),
      .me_o_rd_data(me_o_rd_data), .me_o_rd_we(me_o_rd_we)
   );

   initial me_clk = 1'b0;
   always #5 me_clk = ~me_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge me_clk);
      #1;
   endtask

   // Access size in bytes for a funct3 code; 0 marks an unsupported code.
   function automatic int access_size(input bit [2:0] f3, input bit is_store);
      case (f3)
         3'd0: return 1;
         3'd1: return 2;
         3'd2: return 4;
         3'd4, 3'd5: return is_store ? 0 : (f3 == 3'd4 ? 1 : 2);
         default: return 0;
      endcase
   endfunction

   function automatic bit [3:0] model_be(input bit [2:0] f3, input bit [31:0] addr);
      int off = int'(addr % 4);
      int sz  = access_size(f3, 1'b1);
      bit [3:0] be = '0;
      if (sz != 0 && off + sz <= 4 && (sz != 4 || off == 0))
         for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + sz);
      return be;
   endfunction

   function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] addr);
      int off = int'(addr % 4);
      int sz  = access_size(f3, 1'b0);
      bit [31:0] w = model_mem[(addr / 4) % 256];
      bit [31:0] v = 0;
      if (sz == 0 || off + sz > 4) return 0;
      for (int i = 0; i < sz; i++) v = v | (32'(w[8*(off+i) +: 8]) << (8*i));
      if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1] && sz < 4) v = v | (32'hFFFF_FFFF << (8*sz));
      return v;
   endfunction

   task automatic model_store(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] data);
      bit [3:0] be = model_be(f3, addr);
      int off = int'(addr % 4);
      int idx = int'((addr / 4) % 256);
      for (int k = 0; k < 4; k++)
         if (be[k]) model_mem[idx][8*k +: 8] = data[8*(k-off) +: 8];
   endtask

   task automatic mem_op(input bit is_store, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] data);
      bit [31:0] exp = is_store ? 32'd0 : model_load(f3, addr);
      bit [4:0]  rd  = 5'($urandom_range(1, 31));
      me_i_opcode    = OPCODE_WIDTH'(1) << (is_store ? STORE_WORD : LOAD_WORD);
      me_i_funct3    = f3;
      me_i_alu_value = addr;
      me_i_rs2_data  = data;
      me_i_rd_addr   = rd;
      me_i_rd_data   = $urandom;
      me_i_ce        = 1'b1;
      #1;
      chk("pre_stall", 32'(me_o_stall), 32'd0);
      if (is_store) chk("byte_enable", 32'(u_dut.byte_enable), 32'(model_be(f3, addr)));
      tick();
      chk("busy_stall", 32'(me_o_stall), 32'd1);
      chk("busy_ce", 32'(me_o_ce), 32'd0);
      tick();
      me_i_ce = 1'b0;
      chk("done_stall", 32'(me_o_stall), 32'd0);
      chk("done_ce", 32'(me_o_ce), 32'd1);
      chk("done_rd_we", 32'(me_o_rd_we), is_store ? 32'd0 : 32'd1);
      if (!is_store) begin
         chk("load_data", me_o_load_data, exp);
         chk("load_rd_data", me_o_rd_data, exp);
         chk("load_rd_addr", 32'(me_o_rd_addr), 32'(rd));
      end else begin
         model_store(f3, addr, data);
      end
      $display("txn %s f3=%0d addr=%08h data=%08h exp=%08h", is_store ? "st" : "ld", f3, addr,
               data, exp);
   endtask

   task automatic alu_op(input int op_idx, input bit [4:0] rd, input bit [31:0] data);
      bit exp_we = (op_idx == RTYPE || op_idx == ITYPE || op_idx == JAL || op_idx == JALR ||
                    op_idx == LUI || op_idx == AUIPC);
      me_i_opcode    = OPCODE_WIDTH'(1) << op_idx;
      me_i_funct3    = 3'($urandom);
      me_i_alu_value = $urandom;
      me_i_rd_addr   = rd;
      me_i_rd_data   = data;
      me_i_ce        = 1'b1;
      #1;
      chk("alu_cyc", 32'(u_dut.me_o_cyc), 32'd0);
      tick();
      me_i_ce = 1'b0;
      chk("alu_ce", 32'(me_o_ce), 32'd1);
      chk("alu_rd_addr", 32'(me_o_rd_addr), 32'(rd));
      chk("alu_rd_data", me_o_rd_data, data);
      chk("alu_rd_we", 32'(me_o_rd_we), 32'(exp_we));
      $display("txn alu op=%0d rd=%0d data=%08h", op_idx, rd, data);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      me_rst = 1'b0; me_i_ce = 1'b0; me_i_stall = 1'b0; me_i_flush = 1'b0;
      me_i_rs2_data = '0; me_i_alu_value = '0; me_i_opcode = '0; me_i_funct3 = '0;
      me_i_rd_addr = '0; me_i_rd_data = '0;
      #1;
      chk("rst_ce", 32'(me_o_ce), 32'd0);
      chk("rst_stall", 32'(me_o_stall), 32'd0);
      chk("rst_rd_data", me_o_rd_data, 32'd0);
      chk("rst_opcode", 32'(me_o_opcode), 32'd0);
      tick(); tick();
      me_rst = 1'b1;
      tick();

      // Stores and loads from the documented sequence.
      mem_op(1'b1, FUNCT_SB, 32'd0, 32'h11);
      mem_op(1'b1, FUNCT_SB, 32'd1, 32'h22);
      mem_op(1'b1, FUNCT_SB, 32'd2, 32'h33);
      mem_op(1'b1, FUNCT_SH, 32'd4, 32'h5566);
      mem_op(1'b1, FUNCT_SH, 32'd5, 32'h7788);
      mem_op(1'b1, FUNCT_SW, 32'd8, 32'hCAFEBABE);
      chk("word0", model_mem[0], 32'h00332211);
      chk("word1", model_mem[1], 32'h00778866);
      mem_op(1'b0, FUNCT_LB,  32'd0, 0); chk("lb0", me_o_load_data, 32'h00000011);
      mem_op(1'b0, FUNCT_LBU, 32'd1, 0); chk("lbu1", me_o_load_data, 32'h00000022);
      mem_op(1'b0, FUNCT_LB,  32'd2, 0); chk("lb2", me_o_load_data, 32'h00000033);
      mem_op(1'b0, FUNCT_LBU, 32'd3, 0); chk("lbu3", me_o_load_data, 32'h00000000);
      mem_op(1'b0, FUNCT_LH,  32'd4, 0); chk("lh4", me_o_load_data, 32'hFFFF8866);
      mem_op(1'b0, FUNCT_LHU, 32'd4, 0); chk("lhu4", me_o_load_data, 32'h00008866);
      mem_op(1'b0, FUNCT_LH,  32'd6, 0); chk("lh6", me_o_load_data, 32'h00000077);
      mem_op(1'b0, FUNCT_LW,  32'd8, 0); chk("lw8", me_o_load_data, 32'hCAFEBABE);

      alu_op(RTYPE, 5'd5, 32'h12345678);

      // Downstream stall held while a load is outstanding.
      me_i_opcode = OPCODE_WIDTH'(1) << LOAD_WORD; me_i_funct3 = FUNCT_LW;
      me_i_alu_value = 32'd8; me_i_rd_addr = 5'd9; me_i_ce = 1'b1;
      tick();
      me_i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ce", 32'(me_o_ce), 32'd0);
         chk("stall_hold", me_o_rd_data, 32'h12345678);
         chk("stall_out", 32'(me_o_stall), 32'd1);
      end
      me_i_stall = 1'b0; me_i_ce = 1'b0;
      tick();
      chk("stall_result_ce", 32'(me_o_ce), 32'd1);
      chk("stall_result", me_o_load_data, 32'hCAFEBABE);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_once", 32'(me_o_ce), 32'd0);
      end

      // Flush while BUSY suppresses the completion pulse.
      me_i_opcode = OPCODE_WIDTH'(1) << LOAD_WORD; me_i_funct3 = FUNCT_LW;
      me_i_alu_value = 32'd0; me_i_ce = 1'b1;
      tick();
      me_i_ce = 1'b0; me_i_flush = 1'b1;
      #1;
      chk("flush_comb", 32'(me_o_flush), 32'd1);
      tick();
      me_i_flush = 1'b0;
      chk("flush_ce0", 32'(me_o_ce), 32'd0);
      tick();
      chk("flush_ce1", 32'(me_o_ce), 32'd0);
      chk("flush_idle", 32'(me_o_stall), 32'd0);
      me_i_opcode = OPCODE_WIDTH'(1) << RTYPE; me_i_ce = 1'b1; me_i_flush = 1'b1;
      tick();
      me_i_ce = 1'b0; me_i_flush = 1'b0;
      chk("flush_block", 32'(me_o_ce), 32'd0);

      // Reset in the middle of a store drops the write.
      alu_op(RTYPE, 5'd7, 32'h0BADF00D);
      me_i_opcode = OPCODE_WIDTH'(1) << STORE_WORD; me_i_funct3 = FUNCT_SW;
      me_i_alu_value = 32'd8; me_i_rs2_data = 32'hDEADBEEF; me_i_ce = 1'b1;
      tick();
      me_i_ce = 1'b0;
      chk("pre_rst_busy", 32'(me_o_stall), 32'd1);
      me_rst = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(me_o_stall), 32'd0);
      chk("mid_rst_rd_data", me_o_rd_data, 32'd0);
      chk("mid_rst_rd_addr", 32'(me_o_rd_addr), 32'd0);
      chk("mid_rst_opcode", 32'(me_o_opcode), 32'd0);
      tick(); tick();
      me_rst = 1'b1;
      tick();
      mem_op(1'b0, FUNCT_LW, 32'd8, 0);
      chk("rst_dropped_write", me_o_load_data, 32'hCAFEBABE);

      for (int n = 0; n < 150; n++) begin
         int        kind = $urandom_range(0, 2);
         bit [31:0] addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
         bit [2:0]  f3   = 3'($urandom_range(0, 7));
         case (kind)
            0: mem_op(1'b0, f3, addr, 0);
            1: mem_op(1'b1, f3, addr, $urandom);
            default: begin
               int ops[9] = '{RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE};
               alu_op(ops[$urandom_range(0, 8)], 5'($urandom), $urandom);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the five-stage RV32I pipeline, between the execute and writeback stages.
- Performs byte, halfword and word loads and stores against an internal data RAM, using a single-outstanding Wishbone-style cyc/stb/ack handshake.
- Registers the writeback payload (rd address, rd data, write enable, opcode, funct3) for the writeback stage.
- Generates stall and flush for the upstream stages.

Parameters:
- DWIDTH, 32, data and address width of the datapath.
- AWIDTH, 5, register-file address width.
- FUNCT_WIDTH, 3, funct3 width.
- MEM_DEPTH, 256, data RAM depth in 32-bit words.

Ports:
- me_clk  in  1  clock, rising edge.
- me_rst  in  1  reset; asynchronous, active-low.
- me_i_ce  in  1  valid instruction from execute.
- me_i_stall  in  1  stall from downstream.
- me_i_flush  in  1  flush request.
- me_i_rs2_data  in  DWIDTH  store data.
- me_i_alu_value  in  DWIDTH  byte address of the load/store.
- me_i_opcode  in  OPCODE_WIDTH  one-hot opcode class.
- me_i_funct3  in  FUNCT_WIDTH  access size and sign.
- me_i_rd_addr  in  AWIDTH  destination register.
- me_i_rd_data  in  DWIDTH  non-load result.
- me_o_ce  out  1  valid to writeback.
- me_o_stall  out  1  stall to upstream stages.
- me_o_flush  out  1  flush to upstream stages.
- me_o_opcode  out  OPCODE_WIDTH  registered opcode.
- me_o_funct3  out  FUNCT_WIDTH  registered funct3.
- me_o_load_data  out  DWIDTH  extended load result.
- me_o_rd_addr  out  AWIDTH  registered rd.
- me_o_rd_data  out  DWIDTH  writeback data.
- me_o_rd_we  out  1  register write enable.

Behaviour:
- Reset (me_rst=0, asynchronous): all registered outputs are 0; the FSM goes to IDLE; cyc and stb are 0. RAM contents are not reset and are zero at time 0.
- Accept: an instruction is accepted on a rising edge when me_i_ce=1, me_o_stall=0 and me_i_flush=0.
- Non-memory ops: outputs are registered with 1-cycle latency. me_o_rd_data = me_i_rd_data.
- me_o_rd_we = me_o_ce AND opcode is one of RTYPE, ITYPE, LOAD_WORD, JAL, JALR, LUI or AUIPC.
- FSM has two states, IDLE and BUSY.
  - Accepted LOAD_WORD or STORE_WORD: IDLE goes to BUSY, and cyc and stb are raised.
  - The RAM acks one cycle later. On ack, BUSY goes back to IDLE.
  - The load result is captured and me_o_ce pulses for one cycle.
  - Load latency: me_o_load_data and me_o_rd_data are valid 2 cycles after accept.
- me_o_stall = me_i_stall OR (state==BUSY).
- While me_i_stall=1: all outputs hold and nothing new is accepted.
- Cycles with no accepted instruction drive me_o_ce=0.
- Store byte lanes use off = alu_value[1:0]; the RAM word index is alu_value[log2(MEM_DEPTH)+1:2].
  - SB: byte_enable = 0001 shifted left by off; data is rs2[7:0] replicated into every lane.
  - SH: byte_enable = 0011 shifted left by off; legal only for off 0..2.
  - SW: byte_enable = 1111; legal only for off 0.
- Load data is extracted at byte offset off:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW returns the full word.
- Misaligned accesses (SH/LH/LHU at off 3, SW/LW at off not equal to 0):
  - No RAM write.
  - Load data is 0.
  - The handshake still completes.
- Unknown funct3 is treated the same as a misaligned access.
- Flush:
  - me_o_flush = me_i_flush, combinational.
  - A flush forces me_o_ce=0 on the next edge.
  - If the flush arrives while BUSY, the RAM access completes, but its me_o_ce pulse is suppressed.
- Reset during BUSY aborts the access. A write whose ack has not yet occurred is dropped.
- Addresses beyond MEM_DEPTH wrap modulo the depth.

Decomposition:
- The shared header supplies:
  - OPCODE_WIDTH = 11.
  - One-hot indices RTYPE=0, ITYPE=1, LOAD_WORD=2, STORE_WORD=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, SYSTEM=9, FENCE=10.
  - FUNCT_LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - FUNCT_SB=0, SH=1, SW=2.
- One sub-module, stage_data_ram: single-port RAM with byte enables and a registered one-cycle ack on cyc and stb.
- The store data bus (me_o_store_data), byte_enable, me_o_cyc and me_o_stb are internal signals with exactly these names.

Test Plan:
- Run the stores in order, each with ce high for 2 cycles:
  - SB 0x11@0, SB 0x22@1, SB 0x33@2 -> RAM word0 = 0x00332211; byte_enable 0001, 0010, 0100.
  - SH 0x5566@4, then SH 0x7788@5 -> word1 = 0x00778866; byte_enable 0011, then 0110.
  - SW 0xCAFEBABE@8 -> word2 = 0xCAFEBABE.
  - me_o_stall is high for exactly 1 cycle per access; me_o_rd_we stays 0.
- Loads after the stores above:
  - LB@0 = 0x00000011; LBU@1 = 0x00000022; LB@2 = 0x00000033; LBU@3 = 0x00000000.
  - LH@4 = 0xFFFF8866; LHU@4 = 0x00008866; LH@6 = 0x00000077; LW@8 = 0xCAFEBABE.
  - Each result is valid 2 cycles after accept with me_o_rd_we=1.
- RTYPE rd=5, data 0x12345678 -> 1 cycle later me_o_rd_addr=5, me_o_rd_data=0x12345678, me_o_rd_we=1; cyc stays 0.
- me_i_stall held 3 cycles around an issued load -> outputs hold, no second accept, the result appears once.
- me_i_flush pulse during BUSY -> me_o_flush is high the same cycle; no me_o_ce pulse follows.
- Reset asserted mid-access -> outputs go to 0 immediately; a subsequent LW returns the old RAM value.
